// File: rtl/param_serial_adder.sv
// Bit-serial adder: one full-add per clock, LSB first, with registered result and a done pulse.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN; without it the sub port is ignored.
module param_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] b_load;
    logic             carry_load;

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction as a + ~b + ~cin, so cout=1 means no borrow occurred.
    assign b_load     = sub ? ~b : b;
    assign carry_load = cin ^ sub;
`else
    logic unused_sub;
    assign b_load     = b;
    assign carry_load = cin;
    assign unused_sub = sub;
`endif

    logic             bit_sum;
    logic             bit_carry;
    logic [WIDTH:0]   res_ext;
    logic             unused_res;

    assign bit_sum    = a_sh[0] ^ b_sh[0] ^ carry;
    assign bit_carry  = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
    // New sum bit enters at the MSB; the oldest bit falls off the bottom.
    assign res_ext    = {bit_sum, res_sh};
    assign unused_res = res_ext[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b_load;
                        carry <= carry_load;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= res_ext[WIDTH:1];
                    carry  <= bit_carry;
                    cnt    <= cnt + CW'(1);
                    // Outputs only change here, so sum/cout hold the old result through RUN.
                    if (cnt == LAST_STEP) begin
                        sum   <= res_ext[WIDTH:1];
                        cout  <= bit_carry;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_param_serial_adder.sv
// Scoreboard bench for param_serial_adder (WIDTH=8 main instance, WIDTH=1 corner instance).
// Subtract expectations follow SERIAL_ADDER_SUB_EN when the bench is compiled with it.
module tb_param_serial_adder;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    logic         start1 = 1'b0;
    logic [0:0]   a1 = '0;
    logic [0:0]   b1 = '0;
    logic         cin1 = 1'b0;
    logic         busy1;
    logic         done1;
    logic [0:0]   sum1;
    logic         cout1;

    exp_t         sbq[$];
    int           compared = 0;
    int           mismatched = 0;
    int           cyc = 0;
    logic [W-1:0] last_sum = '0;
    logic         last_cout = 1'b0;

    param_serial_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    param_serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1), .sub(1'b0),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                   input logic mcin, input logic msub);
        exp_t r;
        int   d;
        logic [W:0] t;
        d = 0;
        t = '0;
`ifdef SERIAL_ADDER_SUB_EN
        if (msub) begin
            d = int'(ma) - int'(mb) - int'(mcin);
            r.sum  = d[W-1:0];
            r.cout = (d >= 0);
            return r;
        end
`endif
        t = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mcin};
        r.sum  = t[W-1:0];
        r.cout = t[W];
        return r;
    endfunction

    // Scoreboard: every done pulse must match the oldest pushed expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sbq.size() == 0) begin
                checkOutput("sb_unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                checkOutput("sb_sum", 64'(sum), 64'(e.sum));
                checkOutput("sb_cout", 64'(cout), 64'(e.cout));
                last_sum  = e.sum;
                last_cout = e.cout;
            end
        end
    end

    // Drive one start pulse at a negedge and record the expected result.
    task automatic applyStimulus(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                 input logic tcin, input logic tsub, input bit push);
        @(negedge clk);
        a = ta;
        b = tb;
        cin = tcin;
        sub = tsub;
        start = 1'b1;
        if (push) sbq.push_back(model(ta, tb, tcin, tsub));
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) checkOutput({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    // Full single operation with latency, busy-length and held-output checks.
    task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tcin, input logic tsub);
        logic [W-1:0] held_sum;
        logic         held_cout;
        int           lat;
        int           busy_cnt;
        bit           seen;
        held_sum  = last_sum;
        held_cout = last_cout;
        lat = 0;
        busy_cnt = 0;
        seen = 1'b0;
        applyStimulus(ta, tb, tcin, tsub, 1'b1);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busy_cnt++;
            if (i == 0) begin
                checkOutput({tag, "_held_sum"}, 64'(sum), 64'(held_sum));
                checkOutput({tag, "_held_cout"}, 64'(cout), 64'(held_cout));
            end
            lat++;
        end
        checkOutput({tag, "_done_seen"}, 64'(seen), 64'd1);
        checkOutput({tag, "_latency"}, 64'(lat), 64'(W));
        checkOutput({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(W));
        checkOutput({tag, "_busy_in_done"}, 64'(busy), 64'd0);
        @(negedge clk);
        checkOutput({tag, "_done_width"}, 64'(done), 64'd0);
    endtask

    initial begin
        int t_first;
        int t_second;

        repeat (2) @(negedge clk);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_sum", 64'(sum), 64'd0);
        checkOutput("reset_cout", 64'(cout), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] add cases");
        run_op("ff_plus_01", 8'hFF, 8'h01, 1'b0, 1'b0);
        run_op("a5_plus_5a_c1", 8'hA5, 8'h5A, 1'b1, 1'b0);
        run_op("80_plus_80", 8'h80, 8'h80, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            run_op("rand_add", W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
                   1'($urandom_range(0, 1)), 1'b0);
        end

        $display("[TB] sub-mode cases");
        run_op("05_sub_07", 8'h05, 8'h07, 1'b0, 1'b1);
        run_op("07_sub_05", 8'h07, 8'h05, 1'b0, 1'b1);
        run_op("40_sub_10_c1", 8'h40, 8'h10, 1'b1, 1'b1);
`ifdef SERIAL_ADDER_SUB_EN
        checkOutput("sub_last_sum", 64'(sum), 64'h2F);
`else
        checkOutput("sub_last_sum", 64'(sum), 64'h51);
`endif

        $display("[TB] start during RUN is ignored");
        applyStimulus(8'h12, 8'h34, 1'b0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        a = 8'h77;
        b = 8'h77;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("intrude");
        checkOutput("intrude_sum", 64'(sum), 64'h46);
        repeat (15) @(negedge clk);
        checkOutput("intrude_idle", 64'(busy), 64'd0);

        $display("[TB] start held high");
        @(negedge clk);
        a = 8'h11;
        b = 8'h22;
        cin = 1'b0;
        sub = 1'b0;
        start = 1'b1;
        sbq.push_back(model(8'h11, 8'h22, 1'b0, 1'b0));
        sbq.push_back(model(8'h11, 8'h22, 1'b0, 1'b0));
        wait_done("held1");
        t_first = cyc;
        wait_done("held2");
        t_second = cyc;
        start = 1'b0;
        checkOutput("held_spacing", 64'(t_second - t_first), 64'(W + 2));
        repeat (15) @(negedge clk);

        $display("[TB] reset in the middle of RUN");
        applyStimulus(8'hF0, 8'h0F, 1'b1, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_busy", 64'(busy), 64'd0);
        checkOutput("midrst_done", 64'(done), 64'd0);
        checkOutput("midrst_sum", 64'(sum), 64'd0);
        checkOutput("midrst_cout", 64'(cout), 64'd0);
        last_sum = '0;
        last_cout = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        checkOutput("midrst_stays_idle", 64'(busy), 64'd0);
        run_op("after_reset", 8'h3C, 8'h0F, 1'b1, 1'b0);
        checkOutput("after_reset_sum", 64'(sum), 64'h4C);
        checkOutput("after_reset_cout", 64'(cout), 64'd0);

        $display("[TB] WIDTH=1 instance");
        @(negedge clk);
        a1 = 1'b1;
        b1 = 1'b1;
        cin1 = 1'b1;
        start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        @(negedge clk);
        checkOutput("w1_busy", 64'(busy1), 64'd1);
        checkOutput("w1_done_early", 64'(done1), 64'd0);
        @(negedge clk);
        checkOutput("w1_done", 64'(done1), 64'd1);
        checkOutput("w1_sum", 64'(sum1), 64'd1);
        checkOutput("w1_cout", 64'(cout1), 64'd1);
        @(negedge clk);
        checkOutput("w1_done_width", 64'(done1), 64'd0);

        repeat (3) @(negedge clk);
        checkOutput("sb_pending", 64'(sbq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/param_serial_adder.md
PARAM_SERIAL_ADDER -- requirements
Module: param_serial_adder

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, operand/result width in bits (legal range 1..64).
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 SHALL have port: a  input  WIDTH  operand A; captured on the accepting edge.
REQ-006 SHALL have port: b  input  WIDTH  operand B; captured on the accepting edge.
REQ-007 SHALL have port: cin  input  1  carry-in (borrow-in in subtract mode); captured on the accepting edge.
REQ-008 SHALL have port: sub  input  1  mode select, 1 = subtract; captured on the accepting edge; functional only per REQ-024.
REQ-009 SHALL have port: busy  output  1  high while in RUN.
REQ-010 SHALL have port: done  output  1  one-cycle pulse marking a new result.
REQ-011 SHALL have port: sum  output  WIDTH  registered result; held between operations.
REQ-012 SHALL have port: cout  output  1  registered final carry; held between operations.

Function
REQ-013 SHALL implement FSM states IDLE, RUN and DONE: IDLE->RUN on start=1; RUN->DONE after WIDTH bit-steps; DONE->IDLE unconditionally after one cycle.
REQ-014 SHALL, on the accepting edge (IDLE, start=1), load the A/B shift registers, set the carry flip-flop to cin XOR (effective sub), and clear the bit counter.
REQ-015 SHALL, on each RUN edge, perform one full-add of A[0], B'[0] and carry, shift the sum bit into the MSB of an internal result shift register, shift A/B right by one, update carry, and increment the counter.
REQ-016 SHALL produce the first done edge exactly WIDTH rising edges after the accepting edge (E0 accept; E1..E_WIDTH bit-steps; done=1 between E_WIDTH and E_WIDTH+1).
REQ-017 SHALL load sum and cout from the internal result and carry only on the RUN->DONE edge, so that both outputs keep the previous result throughout RUN.
REQ-018 SHALL drive busy=1 exactly in RUN (WIDTH cycles) and done=1 exactly in DONE (one cycle).
REQ-019 SHALL ignore start in RUN and DONE; a start held continuously SHALL re-trigger only on return to IDLE, giving back-to-back operations every WIDTH+2 cycles.
REQ-020 SHALL size the counter as $clog2(WIDTH+1) bits, with no wrap before the terminal count; WIDTH=1 SHALL give one RUN cycle.
REQ-021 SHALL compute {cout,sum} = a + b + cin modulo 2^(WIDTH+1) in add mode.

Reset
REQ-022 SHALL, while rst_n=0 (asynchronously, including mid-operation), force state=IDLE, busy=0, done=0, sum=0, cout=0, and clear the counter, carry and all shift registers.
REQ-023 SHALL, after rst_n deasserts, remain in IDLE until the first start sampled high; a partially completed operation SHALL be discarded with no done pulse.

Configuration
REQ-024 SHALL use macro SERIAL_ADDER_SUB_EN: when defined, sub=1 SHALL use B' = ~b and initial carry = ~cin, giving sum = a - b - cin modulo 2^WIDTH and cout=1 meaning no borrow; when undefined, the sub port SHALL remain present but be ignored, the block SHALL always add, and no inversion logic SHALL be synthesised.

Verification (WIDTH=8 unless stated)
REQ-025 SHALL cover: a=0xFF, b=0x01, cin=0, start pulse -> busy high for 8 cycles; done rises 8 edges after accept; sum=0x00, cout=1.
REQ-026 SHALL cover, with SERIAL_ADDER_SUB_EN defined: a=0x05, b=0x07, cin=0, sub=1 -> sum=0xFE, cout=0; and a=0x07, b=0x05, sub=1 -> sum=0x02, cout=1.
REQ-027 SHALL cover, with SERIAL_ADDER_SUB_EN undefined: a=0x05, b=0x07, sub=1 -> sum=0x0C, cout=0.
REQ-028 SHALL cover: a start pulse with new operands during RUN -> ignored, with the first result unchanged; start held high -> done pulses spaced 10 cycles apart.
REQ-029 SHALL cover: rst_n asserted at cycle 4 of RUN -> outputs 0 immediately and no done pulse; the next operation a=0x3C, b=0x0F, cin=1 -> sum=0x4C, cout=0.
REQ-030 SHALL cover: WIDTH=1, a=1, b=1, cin=1 -> done one edge after accept; sum=1, cout=1.
